// File: rtl/pix_downscale_3to2.sv
// pix_downscale_3to2: horizontal 3:2 area-weighted pixel decimator.
// Every 3 input pixels (a, b, c) become 2 outputs: (2a+b)/3, (b+2c)/3.
//
// Ports:
//   clk_in     single clock
//   rst        asynchronous, active-low reset
//   in_pix     input pixel, qualified by in_valid
//   in_valid   input handshake valid
//   in_sol     first pixel of a line (restarts grouping)
//   in_eol     last pixel of a line (flushes a partial group)
//   in_ready   block accepts a pixel this cycle
//   out_pix    output pixel, qualified by out_valid
//   out_valid  output handshake valid (show-ahead FIFO not empty)
//   out_eol    last output pixel of a line
//   out_ready  downstream accepts
//   err_frag   sticky: a line restarted in the middle of a group
`timescale 1ns/1ps

module pix_downscale_3to2 #(
    parameter int PIX_W      = 10,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [PIX_W-1:0] in_pix,
    input  logic             in_valid,
    input  logic             in_sol,
    input  logic             in_eol,
    output logic             in_ready,
    output logic [PIX_W-1:0] out_pix,
    output logic             out_valid,
    output logic             out_eol,
    input  logic             out_ready,
    output logic             err_frag
);

    localparam int SW = PIX_W + 2;
    localparam int PW = SW + 10;
    localparam int RW = PW + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 2;
    localparam int EW = PIX_W + 1;

    localparam logic [PW-1:0] K_MUL = PW'(683);
    localparam logic [RW-1:0] K_RND = RW'(1024);
    localparam logic [SW-1:0] Y_MAX = SW'((1 << PIX_W) - 1);

    // PH_EOL is the extra cycle that emits 3b after a line ends at PH1.
    typedef enum logic [1:0] {
        PH0    = 2'd0,
        PH1    = 2'd1,
        PH2    = 2'd2,
        PH_EOL = 2'd3
    } phase_e;

    phase_e           phase_q, phase_d;
    phase_e           phase_eff;
    logic [PIX_W-1:0] a_q, a_d;
    logic [PIX_W-1:0] b_q, b_d;
    logic             err_q, err_d;

    logic             accept;
    logic             iss_valid;
    logic             iss_eol;
    logic [SW-1:0]    iss_sum;
    logic [SW-1:0]    pix_x;
    logic [SW-1:0]    a_x;
    logic [SW-1:0]    b_x;

    logic             s1_valid_q, s1_valid_d;
    logic             s1_eol_q, s1_eol_d;
    logic [SW-1:0]    s1_sum_q, s1_sum_d;

    logic             s2_valid_q, s2_valid_d;
    logic             s2_eol_q, s2_eol_d;
    logic [PW-1:0]    s2_prod_q, s2_prod_d;

    logic             s3_valid_q, s3_valid_d;
    logic             s3_eol_q, s3_eol_d;
    logic [PIX_W-1:0] s3_y_q, s3_y_d;

    logic [RW-1:0]    rnd;
    logic [SW-1:0]    y_full;

    logic [EW-1:0]    mem_q [FIFO_DEPTH];
    logic [EW-1:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [EW-1:0]    fifo_head;
    logic             push;
    logic             pop;
    logic [CW-1:0]    occ;

    // ------------------------------------------------------------------
    // Handshake and occupancy
    // ------------------------------------------------------------------
    // Occupancy counts every sample already committed to reach the FIFO.
    // Keeping it at or below DEPTH-2 leaves room for the one sample issued
    // on accept plus the extra 3b sample of a PH1 line end.
    always_comb begin
        occ = CW'(count_q) + CW'(s1_valid_q)
            + CW'(s2_valid_q) + CW'(s3_valid_q);
    end

    assign in_ready = rst
                    & (phase_q != PH_EOL)
                    & (occ <= CW'(FIFO_DEPTH - 2));

    assign accept = in_valid & in_ready;

    // ------------------------------------------------------------------
    // Phase FSM: group a/b/c and issue weighted sums
    // ------------------------------------------------------------------
    always_comb begin
        pix_x = SW'(in_pix);
        a_x   = SW'(a_q);
        b_x   = SW'(b_q);
    end

    // A start-of-line pixel always opens a new group.
    assign phase_eff = in_sol ? PH0 : phase_q;

    always_comb begin
        phase_d   = phase_q;
        a_d       = a_q;
        b_d       = b_q;
        err_d     = err_q;
        iss_valid = 1'b0;
        iss_eol   = 1'b0;
        iss_sum   = '0;

        if (phase_q == PH_EOL) begin
            iss_valid = 1'b1;
            iss_eol   = 1'b1;
            iss_sum   = (b_x << 1) + b_x;
            phase_d   = PH0;
        end else if (accept) begin
            if (in_sol && (phase_q != PH0)) begin
                err_d = 1'b1;
            end
            unique case (phase_eff)
                PH0: begin
                    a_d = in_pix;
                    if (in_eol) begin
                        iss_valid = 1'b1;
                        iss_eol   = 1'b1;
                        iss_sum   = (pix_x << 1) + pix_x;
                        phase_d   = PH0;
                    end else begin
                        phase_d = PH1;
                    end
                end
                PH1: begin
                    b_d       = in_pix;
                    iss_valid = 1'b1;
                    iss_sum   = (a_x << 1) + pix_x;
                    phase_d   = in_eol ? PH_EOL : PH2;
                end
                PH2: begin
                    iss_valid = 1'b1;
                    iss_eol   = in_eol;
                    iss_sum   = b_x + (pix_x << 1);
                    phase_d   = PH0;
                end
                default: begin
                    phase_d = PH0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            phase_q <= PH0;
            a_q     <= '0;
            b_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
        end
    end

    assign err_frag = err_q;

    // ------------------------------------------------------------------
    // Divide-by-3 pipeline: sum -> product -> rounded, clamped Y
    // ------------------------------------------------------------------
    always_comb begin
        s1_valid_d = iss_valid;
        s1_eol_d   = iss_eol;
        s1_sum_d   = iss_sum;

        s2_valid_d = s1_valid_q;
        s2_eol_d   = s1_eol_q;
        s2_prod_d  = PW'(s1_sum_q) * K_MUL;

        // 683/2048 approximates 1/3; adding 1024 rounds to nearest.
        rnd    = {1'b0, s2_prod_q} + K_RND;
        y_full = SW'(rnd >> 11);

        s3_valid_d = s2_valid_q;
        s3_eol_d   = s2_eol_q;
        s3_y_d     = (y_full > Y_MAX) ? Y_MAX[PIX_W-1:0]
                                      : y_full[PIX_W-1:0];
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_eol_q   <= 1'b0;
            s1_sum_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_eol_q   <= 1'b0;
            s2_prod_q  <= '0;
            s3_valid_q <= 1'b0;
            s3_eol_q   <= 1'b0;
            s3_y_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_eol_q   <= s1_eol_d;
            s1_sum_q   <= s1_sum_d;
            s2_valid_q <= s2_valid_d;
            s2_eol_q   <= s2_eol_d;
            s2_prod_q  <= s2_prod_d;
            s3_valid_q <= s3_valid_d;
            s3_eol_q   <= s3_eol_d;
            s3_y_q     <= s3_y_d;
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead output FIFO
    // ------------------------------------------------------------------
    // Input throttling guarantees space, so a stage-3 sample always pushes.
    assign push = s3_valid_q;
    assign pop  = out_valid & out_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = {s3_eol_q, s3_y_q};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign fifo_head = mem_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign out_pix   = out_valid ? fifo_head[PIX_W-1:0] : '0;
    assign out_eol   = out_valid & fifo_head[PIX_W];

endmodule

// File: tb/tb_pix_downscale_3to2.sv
// tb_pix_downscale_3to2: directed + random bench for the 3:2 decimator.
// Expected outputs come from a line/group reference model.
`timescale 1ns/1ps

module tb_pix_downscale_3to2;

    localparam int PIX_W = 10;

    logic             clk_in;
    logic             rst;
    logic [PIX_W-1:0] in_pix;
    logic             in_valid;
    logic             in_sol;
    logic             in_eol;
    logic             in_ready;
    logic [PIX_W-1:0] out_pix;
    logic             out_valid;
    logic             out_eol;
    logic             out_ready;
    logic             err_frag;

    pix_downscale_3to2 #(.PIX_W(PIX_W), .FIFO_DEPTH(8)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .in_pix    (in_pix),
        .in_valid  (in_valid),
        .in_sol    (in_sol),
        .in_eol    (in_eol),
        .in_ready  (in_ready),
        .out_pix   (out_pix),
        .out_valid (out_valid),
        .out_eol   (out_eol),
        .out_ready (out_ready),
        .err_frag  (err_frag)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic             eol;
        logic [PIX_W-1:0] pix;
    } smp_t;

    int   checks = 0;
    int   errors = 0;
    smp_t exp_q [$];
    smp_t out_log [$];
    int   grp [$];
    bit   err_exp = 0;
    bit   stall_seen = 0;
    bit   stalled = 0;
    smp_t hold;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Area-weighted average of a sum of 3 pixels, as fixed-point /3.
    function automatic int y3(input int s);
        int y;
        y = (s * 683 + 1024) >> 11;
        if (y > 1023) y = 1023;
        return y;
    endfunction

    function automatic void emit(input int s, input bit e);
        smp_t x;
        x.pix = 10'(y3(s));
        x.eol = e;
        exp_q.push_back(x);
    endfunction

    // Group view of a line: outputs depend on how many pixels are held.
    function automatic void model(input int p, input bit s, input bit e);
        int n;
        if (s) begin
            if (grp.size() != 0) err_exp = 1;
            grp.delete();
        end
        grp.push_back(p);
        n = grp.size();
        if (n == 2) emit(2 * grp[0] + grp[1], 0);
        if (n == 3) emit(grp[1] + 2 * grp[2], e);
        if (e && n == 1) emit(3 * grp[0], 1);
        if (e && n == 2) emit(3 * grp[1], 1);
        if (e || n == 3) grp.delete();
    endfunction

    task automatic send(input int p, input bit s, input bit e);
        int w = 0;
        bit done = 0;
        in_pix   = p[PIX_W-1:0];
        in_sol   = s;
        in_eol   = e;
        in_valid = 1'b1;
        while (!done && w < 200) begin
            if (in_ready === 1'b1) begin
                @(posedge clk_in); #1;
                done = 1;
            end else begin
                w++;
                if (w > 20 && out_ready == 1'b0) begin
                    out_ready  = 1'b1;
                    stall_seen = 1;
                end
                @(posedge clk_in); #1;
            end
        end
        in_valid = 1'b0;
        in_sol   = 1'b0;
        in_eol   = 1'b0;
        chk("send_accept", 32'(done), 32'd1);
        if (done) model(p, s, e);
    endtask

    task automatic drain();
        int w = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && w < 400) begin
            @(posedge clk_in); #1;
            w++;
        end
        repeat (3) @(posedge clk_in);
        #1;
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_log(input string tag, input int idx,
                           input int pix, input bit eol);
        smp_t g;
        g = '1;
        if (idx < out_log.size()) g = out_log[idx];
        chk(tag, {21'd0, g.eol, g.pix}, {21'd0, eol, pix[PIX_W-1:0]});
    endtask

    // Output monitor: scoreboard against the model, stall stability.
    always @(negedge clk_in) begin
        if (!rst) begin
            stalled = 0;
        end else begin
            if (stalled && out_valid) begin
                chk("hold_stable", {21'd0, out_eol, out_pix},
                    {21'd0, hold.eol, hold.pix});
            end
            if (out_valid && out_ready) begin
                chk("unexpected_out", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    smp_t e;
                    e = exp_q.pop_front();
                    chk("out_sample", {21'd0, out_eol, out_pix},
                        {21'd0, e.eol, e.pix});
                end
                out_log.push_back({out_eol, out_pix});
                stalled = 0;
            end else if (out_valid) begin
                stalled  = 1;
                hold.pix = out_pix;
                hold.eol = out_eol;
            end else begin
                stalled = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clk_in    = 1'b0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_pix    = '0;
        in_sol    = 1'b0;
        in_eol    = 1'b0;
        out_ready = 1'b0;

        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pix", 32'(out_pix), 32'd0);
        chk("rst_out_eol", 32'(out_eol), 32'd0);
        chk("rst_err_frag", 32'(err_frag), 32'd0);
        repeat (3) @(posedge clk_in);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk_in); #1;
        out_ready = 1'b1;

        // Basic line 300, 600, 900 and first-output latency.
        out_log.delete();
        send(300, 1, 0);
        send(600, 0, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            chk("latency", 32'(out_valid), 32'(k == 3));
        end
        @(posedge clk_in); #1;
        send(900, 0, 1);
        drain();
        chk("t1_count", 32'(out_log.size()), 32'd2);
        chk_log("t1_o0", 0, 400, 0);
        chk_log("t1_o1", 1, 800, 1);

        // Full-scale and rounding of small sums.
        out_log.delete();
        send(1023, 0, 0);
        send(1023, 0, 0);
        send(1023, 0, 0);
        send(0, 0, 0);
        send(1, 0, 0);
        send(2, 0, 0);
        drain();
        chk("t2_count", 32'(out_log.size()), 32'd4);
        chk_log("t2_o0", 0, 1023, 0);
        chk_log("t2_o1", 1, 1023, 0);
        chk_log("t2_o2", 2, 0, 0);
        chk_log("t2_o3", 3, 2, 0);

        // Line ending at PH1: extra 3b sample and one-cycle ready gap.
        out_log.delete();
        send(100, 1, 0);
        send(200, 0, 1);
        chk("t3_gap", 32'(in_ready), 32'd0);
        @(posedge clk_in); #1;
        chk("t3_gap_end", 32'(in_ready), 32'd1);
        drain();
        chk("t3_count", 32'(out_log.size()), 32'd2);
        chk_log("t3_o0", 0, 133, 0);
        chk_log("t3_o1", 1, 200, 1);
        chk("t3_err", 32'(err_frag), 32'd0);

        // Fragmented line restart.
        out_log.delete();
        send(10, 1, 0);
        send(20, 1, 0);
        send(30, 1, 0);
        send(60, 0, 0);
        send(90, 0, 1);
        drain();
        chk("t4_err", 32'(err_frag), 32'd1);
        chk("t4_count", 32'(out_log.size()), 32'd2);
        chk_log("t4_o0", 0, 40, 0);
        chk_log("t4_o1", 1, 80, 1);

        // Backpressure: 30-pixel line with the output stalled.
        out_log.delete();
        out_ready  = 1'b0;
        stall_seen = 0;
        for (int i = 0; i < 30; i++) begin
            send((i * 37 + 5) % 1024, i == 0, i == 29);
        end
        drain();
        chk("t5_stalled", 32'(stall_seen), 32'd1);
        chk("t5_count", 32'(out_log.size()), 32'd20);

        // Random lines with random output backpressure.
        for (int l = 0; l < 10; l++) begin
            int len;
            len = $urandom_range(1, 11);
            for (int k = 0; k < len; k++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                send($urandom_range(0, 1023), k == 0, k == len - 1);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk_in); #1;
                end
            end
        end
        drain();
        chk("rand_err", 32'(err_frag), 32'(err_exp));

        // Reset mid-line with the FIFO partly full.
        out_log.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send(100 + i * 10, i == 0, 0);
        end
        repeat (5) @(posedge clk_in);
        #1;
        chk("t6_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_err", 32'(err_frag), 32'd0);
        chk("t6_pix", 32'(out_pix), 32'd0);
        exp_q.delete();
        grp.delete();
        err_exp = 0;
        @(posedge clk_in); #1;
        rst = 1'b1;
        @(posedge clk_in); #1;
        out_ready = 1'b1;
        out_log.delete();
        send(30, 1, 0);
        send(60, 0, 0);
        send(90, 0, 1);
        drain();
        chk("t6_count", 32'(out_log.size()), 32'd2);
        chk_log("t6_o0", 0, 40, 0);
        chk_log("t6_o1", 1, 80, 1);
        chk("t6_err_after", 32'(err_frag), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
